dl_watchdog_report_unit: RTL and testbench
==========================================

Name: dl_watchdog_report_unit

Overview:
- Parametrised successor to the cosim deadlock reporter: detects stalled dataflow processes and reports them without the current unit's false alarms.
- Debounces each process's blocked flag with a per-process stall timer. Freezes the set of confirmed-stalled processes and streams their indices out one per handshake, lowest index first.
- Sits beside the dataflow region in the simulation/debug harness. Its outputs feed the report printer and the stop/continue logic.
- Optional re-arm mode lets detection run again after the design recovers.

Parameters:
- PROC_NUM, 4, number of monitored processes (>=1).
- CNT_W, 8, stall counter width.
- STALL_THRESH, 16, consecutive blocked cycles before a process is confirmed (1..2^CNT_W-1).
- REARM, 0: 0 = latch forever after a report; 1 = return to idle once all blocked flags drop.
- IDX_W, max(1,$clog2(PROC_NUM)), index width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- dl_in_vec  in  PROC_NUM  per-process blocked flag, sampled each rising edge.
- rpt_ready  in  1  consumer accepts rpt_idx.
- rpt_valid  out  1  rpt_idx valid.
- rpt_idx  out  IDX_W  index of the reported stalled process.
- rpt_last  out  1  current report is the final one of this event.
- dl_detect_out  out  1  high from capture until re-arm/reset.
- token_clear  out  1  one-cycle pulse when an event's reporting completes.
- confirmed_vec  out  PROC_NUM  live debounced stall flags.
- event_cnt  out  8  number of completed events, saturating at 255.

Behaviour:
- Reset: all counters, detect_reg, done_reg and event_cnt go to 0; state goes to IDLE. All outputs are 0.
- Stall counter per process i, updated every cycle in every state:
  - dl_in_vec[i]=0: cnt[i] <= 0.
  - otherwise, if cnt[i] < STALL_THRESH: cnt[i] <= cnt[i]+1.
  - confirmed_vec[i] = (cnt[i]==STALL_THRESH). It is registered: it rises STALL_THRESH edges after the first edge sampling dl_in_vec[i]=1.
- A single-cycle drop of dl_in_vec[i] restarts that process's count.
- FSM states: IDLE, REPORT, DONE.
- IDLE:
  - If |confirmed_vec: detect_reg <= confirmed_vec, done_reg <= 0, next state REPORT.
  - dl_detect_out rises on the same edge (dl_detect_out = |detect_reg).
- REPORT:
  - detect_reg is frozen; confirmations arriving during REPORT are ignored for this event.
  - pend = detect_reg & ~done_reg.
  - rpt_valid = 1; rpt_idx = lowest set index of pend; rpt_last = (pend has exactly one bit set).
  - rpt_idx and rpt_valid hold stable while rpt_ready=0.
  - On rpt_valid & rpt_ready: done_reg sets the reported bit.
  - If rpt_last was set on that accept: next state DONE, token_clear=1 for that cycle (combinational on the accepting cycle), event_cnt increments (saturating).
  - A single-process event completes in one handshake.
- DONE:
  - rpt_valid = 0; dl_detect_out stays 1.
  - REARM=0: remain in DONE until reset.
  - REARM=1: when dl_in_vec == 0 for one sampled cycle, clear detect_reg and done_reg and go to IDLE. dl_detect_out falls on that edge.
  - Counters restart from 0, so a new event needs a full STALL_THRESH again.
- Reset asserted mid-REPORT aborts the event immediately: no token_clear, event_cnt cleared.
- rpt_ready high outside REPORT has no effect.

Test Plan:
- T1, PROC_NUM=4, THRESH=16: dl_in_vec=4'b0101 held from cycle 0 -> confirmed_vec=0101 at edge 16; rpt_valid next cycle. With rpt_ready=1: rpt_idx=0 (rpt_last=0), then rpt_idx=2 (rpt_last=1, token_clear pulse). Then DONE, event_cnt=1, dl_detect_out=1.
- T2, debounce: bit1 high 15 cycles, low 1, high 15 -> confirmed_vec never set, state stays IDLE, dl_detect_out=0.
- T3, back-pressure: single stall on bit3, rpt_ready=0 for 10 cycles -> rpt_valid=1 and rpt_idx=3 stable throughout. On rpt_ready=1: token_clear for exactly 1 cycle, rpt_last=1.
- T4, freeze: bit0 confirmed and in REPORT with rpt_ready=0; bit2 then confirms -> only index 0 is reported, and bit2 is not part of this event.
- T5, REARM=1: after the T1 event, drop all inputs -> IDLE. Re-stall bit1 -> rpt_idx=1 after 16+1 cycles; event_cnt=2.
- T6, reset mid-REPORT (after the first accept in T1) -> all outputs 0 immediately. After release with inputs still high: a fresh event after 16 cycles starting at rpt_idx=0; event_cnt stays 0 until that event completes.

Source files
------------

// File: rtl/dl_watchdog_report_unit.sv
// Deadlock watchdog: debounces per-process blocked flags, freezes the confirmed set and
// streams the stalled process indices out one per handshake, lowest index first.
module dl_watchdog_report_unit #(
  parameter int unsigned PROC_NUM     = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned STALL_THRESH = 16,
  parameter int unsigned REARM        = 0,
  parameter int unsigned IDX_W        = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [PROC_NUM-1:0] i_dl_in_vec,
  input  logic                i_rpt_ready,
  output logic                o_rpt_valid,
  output logic [IDX_W-1:0]    o_rpt_idx,
  output logic                o_rpt_last,
  output logic                o_dl_detect_out,
  output logic                o_token_clear,
  output logic [PROC_NUM-1:0] o_confirmed_vec,
  output logic [7:0]          o_event_cnt
);

  typedef enum logic [1:0] {StIdle, StReport, StDone} state_e;

  localparam logic [CNT_W-1:0]    Thresh = CNT_W'(STALL_THRESH);
  localparam logic [PROC_NUM-1:0] OneP   = PROC_NUM'(1);

  state_e              r_state, w_state_d;
  logic [PROC_NUM-1:0] r_detect, w_detect_d;
  logic [PROC_NUM-1:0] r_done, w_done_d;
  logic [7:0]          r_event_cnt, w_event_cnt_d;
  logic [PROC_NUM-1:0] w_confirmed;
  logic [PROC_NUM-1:0] w_pend;
  logic [PROC_NUM-1:0] w_sel;
  logic [IDX_W-1:0]    w_idx;
  logic                w_last;
  logic                w_valid;
  logic                w_token;

  // Stall counters run in every state; any sampled low restarts the count.
  for (genvar g = 0; g < PROC_NUM; g++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
        r_cnt <= '0;
      end else if (!i_dl_in_vec[g]) begin
        r_cnt <= '0;
      end else if (r_cnt < Thresh) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
    assign w_confirmed[g] = (r_cnt == Thresh);
  end

  assign w_pend = r_detect & ~r_done;
  assign w_sel  = w_pend & (~w_pend + OneP);
  assign w_last = (w_pend != '0) && ((w_pend & (w_pend - OneP)) == '0);

  always_comb begin
    w_idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_detect_d    = r_detect;
    w_done_d      = r_done;
    w_event_cnt_d = r_event_cnt;
    w_valid       = 1'b0;
    w_token       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (|w_confirmed) begin
          w_detect_d = w_confirmed;
          w_done_d   = '0;
          w_state_d  = StReport;
        end
      end
      StReport: begin
        w_valid = 1'b1;
        if (i_rpt_ready) begin
          w_done_d = r_done | w_sel;
          if (w_last) begin
            w_state_d = StDone;
            w_token   = 1'b1;
            if (r_event_cnt != 8'hFF) begin
              w_event_cnt_d = r_event_cnt + 8'd1;
            end
          end
        end
      end
      StDone: begin
        if ((REARM != 0) && (i_dl_in_vec == '0)) begin
          w_detect_d = '0;
          w_done_d   = '0;
          w_state_d  = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_detect    <= '0;
      r_done      <= '0;
      r_event_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_detect    <= w_detect_d;
      r_done      <= w_done_d;
      r_event_cnt <= w_event_cnt_d;
    end
  end

  assign o_rpt_valid     = w_valid;
  assign o_rpt_idx       = w_idx;
  assign o_rpt_last      = w_valid && w_last;
  assign o_dl_detect_out = |r_detect;
  assign o_token_clear   = w_token;
  assign o_confirmed_vec = w_confirmed;
  assign o_event_cnt     = r_event_cnt;

endmodule

// File: tb/tb_dl_watchdog_report_unit.sv
// Scoreboard bench: two instances (latching and re-arming); expected reports are queued by the
// stimulus and popped by per-instance monitors on each accepted handshake.
module tb_dl_watchdog_report_unit;

  localparam int unsigned PN = 4;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          rst0, rst1;
  logic [PN-1:0] dl0, dl1;
  logic          rdy0, rdy1;
  logic          v0, v1, last0, last1, det0, det1, tok0, tok1;
  logic [IW-1:0] idx0, idx1;
  logic [PN-1:0] conf0, conf1;
  logic [7:0]    evt0, evt1;

  int tests = 0;
  int fails = 0;
  int q0[$];
  int q1[$];

  always #5 clk = ~clk;

  dl_watchdog_report_unit #(
    .PROC_NUM(PN), .CNT_W(8), .STALL_THRESH(16), .REARM(0), .IDX_W(IW)
  ) u_dut0 (
    .i_clock(clk), .i_reset(rst0), .i_dl_in_vec(dl0), .i_rpt_ready(rdy0),
    .o_rpt_valid(v0), .o_rpt_idx(idx0), .o_rpt_last(last0), .o_dl_detect_out(det0),
    .o_token_clear(tok0), .o_confirmed_vec(conf0), .o_event_cnt(evt0)
  );

  dl_watchdog_report_unit #(
    .PROC_NUM(PN), .CNT_W(8), .STALL_THRESH(16), .REARM(1), .IDX_W(IW)
  ) u_dut1 (
    .i_clock(clk), .i_reset(rst1), .i_dl_in_vec(dl1), .i_rpt_ready(rdy1),
    .o_rpt_valid(v1), .o_rpt_idx(idx1), .o_rpt_last(last1), .o_dl_detect_out(det1),
    .o_token_clear(tok1), .o_confirmed_vec(conf1), .o_event_cnt(evt1)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected entry encoding: last*4 + idx.
  always @(negedge clk) begin
    if (!rst0) begin
      if (tok0 && !(v0 && rdy0)) chk("tok0_spurious", 1, 0);
      if (v0 && rdy0) begin
        if (q0.size() == 0) begin
          chk("rpt0_unexpected", {29'd0, last0, idx0}, -1);
        end else begin
          automatic int e = q0.pop_front();
          chk("rpt0", {29'd0, last0, idx0}, e);
          chk("tok0", {31'd0, tok0}, e / 4);
        end
      end
    end
    if (!rst1) begin
      if (tok1 && !(v1 && rdy1)) chk("tok1_spurious", 1, 0);
      if (v1 && rdy1) begin
        if (q1.size() == 0) begin
          chk("rpt1_unexpected", {29'd0, last1, idx1}, -1);
        end else begin
          automatic int e = q1.pop_front();
          chk("rpt1", {29'd0, last1, idx1}, e);
          chk("tok1", {31'd0, tok1}, e / 4);
        end
      end
    end
  end

  task automatic reset0();
    rst0 = 1'b1;
    dl0  = '0;
    rdy0 = 1'b0;
    tick(2);
    chk("reset0_outs", {13'd0, v0, idx0, last0, det0, tok0, conf0, evt0}, 0);
    rst0 = 1'b0;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    dl0 = '0; dl1 = '0; rdy0 = 1'b0; rdy1 = 1'b0;
    tick(2);
    chk("reset1_outs", {13'd0, v1, idx1, last1, det1, tok1, conf1, evt1}, 0);
    rst1 = 1'b0;

    // T2: debounce, a one-cycle drop restarts the count
    reset0();
    dl0 = 4'b0010;
    tick(15);
    dl0 = 4'b0000;
    tick(1);
    dl0 = 4'b0010;
    tick(15);
    chk("t2_conf", int'(conf0), 0);
    chk("t2_det", int'(det0), 0);
    chk("t2_valid", int'(v0), 0);
    dl0 = '0;

    // T1: two-process event, lowest index first
    reset0();
    dl0 = 4'b0101; rdy0 = 1'b1;
    tick(15);
    chk("t1_conf_early", int'(conf0), 0);
    tick(1);
    chk("t1_conf", int'(conf0), 5);
    chk("t1_valid_early", int'(v0), 0);
    q0.push_back(0); q0.push_back(4 + 2);
    tick(1);
    chk("t1_det", int'(det0), 1);
    tick(2);
    chk("t1_evt", int'(evt0), 1);
    chk("t1_done_valid", int'(v0), 0);
    chk("t1_done_det", int'(det0), 1);
    // Latching variant ignores recovery and new stalls
    dl0 = '0;
    tick(3);
    chk("latch_det", int'(det0), 1);
    dl0 = 4'b0001;
    tick(20);
    chk("latch_valid", int'(v0), 0);
    chk("latch_evt", int'(evt0), 1);

    // T6: reset mid-report, then a fresh event
    reset0();
    dl0 = 4'b0101; rdy0 = 1'b1;
    q0.push_back(0);
    tick(18);
    chk("t6_pre_idx", int'(idx0), 2);
    rst0 = 1'b1;
    #1;
    chk("t6_abort_outs", {13'd0, v0, idx0, last0, det0, tok0, conf0, evt0}, 0);
    tick(1);
    rst0 = 1'b0;
    q0.push_back(0); q0.push_back(4 + 2);
    tick(15);
    chk("t6_conf_early", int'(conf0), 0);
    tick(1);
    chk("t6_conf", int'(conf0), 5);
    tick(1);
    chk("t6_idx", int'(idx0), 0);
    chk("t6_evt_a", int'(evt0), 0);
    tick(1);
    chk("t6_evt_b", int'(evt0), 0);
    tick(1);
    chk("t6_evt_c", int'(evt0), 1);

    // T3: back-pressure holds the report stable
    reset0();
    dl0 = 4'b1000;
    tick(17);
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold", {29'd0, v0, idx0}, 4 + 3);
      chk("t3_tok_idle", int'(tok0), 0);
      tick(1);
    end
    q0.push_back(4 + 3);
    rdy0 = 1'b1;
    #1;
    chk("t3_tok", int'(tok0), 1);
    chk("t3_last", int'(last0), 1);
    tick(1);
    chk("t3_tok_after", int'(tok0), 0);
    chk("t3_valid_after", int'(v0), 0);
    chk("t3_evt", int'(evt0), 1);

    // T4: late confirmation is not part of the frozen event
    reset0();
    dl0 = 4'b0001;
    tick(17);
    dl0 = 4'b0101;
    tick(16);
    chk("t4_conf", int'(conf0), 5);
    chk("t4_idx_last", {29'd0, last0, idx0}, 4 + 0);
    q0.push_back(4 + 0);
    rdy0 = 1'b1;
    tick(1);
    chk("t4_evt", int'(evt0), 1);
    tick(3);
    chk("t4_valid_after", int'(v0), 0);

    // T5: re-arm after recovery
    dl1 = 4'b0101; rdy1 = 1'b1;
    q1.push_back(0); q1.push_back(4 + 2);
    tick(19);
    chk("t5_evt1", int'(evt1), 1);
    chk("t5_det1", int'(det1), 1);
    dl1 = '0;
    tick(1);
    chk("t5_det_fall", int'(det1), 0);
    dl1 = 4'b0010;
    q1.push_back(4 + 1);
    tick(16);
    chk("t5_conf", int'(conf1), 2);
    chk("t5_valid_early", int'(v1), 0);
    tick(1);
    chk("t5_report", {28'd0, v1, last1, idx1}, 8 + 4 + 1);
    tick(1);
    chk("t5_evt2", int'(evt1), 2);
    chk("t5_det2", int'(det1), 1);

    // Event counter saturates at 255
    for (int k = 0; k < 254; k++) begin
      dl1 = '0;
      tick(1);
      dl1 = 4'b0001;
      q1.push_back(4 + 0);
      tick(18);
      if (k == 252) chk("sat_255", int'(evt1), 255);
    end
    chk("sat_hold", int'(evt1), 255);

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
